// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared fetch-stage types: FSM states and queue entry layout
package rv32i_types;

  localparam int DEFAULT_XLEN = 32;

  // IDLE: nothing outstanding; REQ: response will be queued; REQ_DROP: response will be discarded
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    REQ_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// rtl/fetch_queue_unit_fifo.sv - DEPTH-entry circular buffer with push, pop, flush and occupancy
module fetch_fifo
  import rv32i_types::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  entry_t                     i_push_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output entry_t                     o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A pop frees a slot in the same cycle, so a push into a full queue is legal alongside a pop
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  // Pointers and occupancy; flush takes precedence over any push or pop in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero until the first push
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - instruction fetch front end: PC, single-outstanding I-cache request, fetch queue
module fetch_queue_unit
  import rv32i_types::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0060
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_jalr,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_resp,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc_next
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } q_entry_t;

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_next;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] w_req_addr_next;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_issue;
  logic            w_push;
  logic            w_flush;
  logic            w_pop;
  logic            w_can_issue;
  logic            w_room_after_push;
  logic [AW:0]     w_count;
  logic [AW:0]     w_count_next;
  logic            w_empty;
  logic            w_full;
  q_entry_t        w_head;
  q_entry_t        w_push_data;

  assign w_target     = redirect_jalr ? {redirect_pc[XLEN-1:1], 1'b0} : redirect_pc;
  assign w_pc_plus4   = r_fetch_pc + XLEN'(4);
  assign w_pop        = id_valid && id_ready;
  assign w_count_next = w_count - (AW+1)'(w_pop);

  // Issue only with a free slot after this cycle's pop; held off while reset is asserted
  assign w_can_issue       = rst_n && (!w_full || w_pop);
  assign w_room_after_push = (w_count_next < LAST_CNT);
  assign w_push_data       = '{pc: r_fetch_pc, instr: imem_rdata};

  // Next-state, PC and queue control; a redirect overrides everything, including a same-cycle response
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_addr_next = r_req_addr;
    w_issue         = 1'b0;
    w_push          = 1'b0;
    w_flush         = 1'b0;
    if (redirect_valid) begin
      w_flush         = 1'b1;
      w_fetch_pc_next = w_target;
      if (r_state == IDLE || imem_resp) w_state_next = IDLE;
      else                              w_state_next = REQ_DROP;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_can_issue) begin
            w_issue         = 1'b1;
            w_req_addr_next = r_fetch_pc;
            w_state_next    = REQ;
          end
        end
        REQ: begin
          if (imem_resp) begin
            w_push          = 1'b1;
            w_fetch_pc_next = w_pc_plus4;
            if (w_room_after_push) begin
              w_req_addr_next = w_pc_plus4;
              w_state_next    = REQ;
            end else begin
              w_state_next    = IDLE;
            end
          end
        end
        REQ_DROP: begin
          if (imem_resp) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM state, fetch PC and the latched request address the cache sees while waiting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= w_req_addr_next;
    end
  end

  assign imem_read    = w_issue || (r_state != IDLE);
  assign imem_address = (r_state == IDLE) ? r_fetch_pc : r_req_addr;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (q_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  assign id_valid   = !w_empty;
  assign id_pc      = w_head.pc;
  assign id_instr   = w_head.instr;
  assign id_pc_next = w_head.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit with a latency-controlled I-cache model
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        redirect_jalr = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_next;

  int          n_checks = 0;
  int          n_fail = 0;
  int          lat = 1;
  logic [31:0] exp_req[$];
  logic [31:0] exp_pop[$];

  fetch_queue_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h4000_0060)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_jalr  (redirect_jalr),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_pc_next     (id_pc_next)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_drained(input string name);
    check({name, "_req_left"}, 32'(exp_req.size()), 32'd0);
    check({name, "_pop_left"}, 32'(exp_pop.size()), 32'd0);
    exp_req.delete();
    exp_pop.delete();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_jalr  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_read", {31'b0, imem_read}, 32'd0);
    check("rst_id_valid",  {31'b0, id_valid},  32'd0);
    check("rst_id_pc",     id_pc,              32'd0);
    check("rst_id_instr",  id_instr,           32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // I-cache model: latches each new request, checks it against the expected address list,
  // checks the request is held, and answers lat cycles later with data ~address
  initial begin : cache
    logic        pending;
    logic [31:0] addr;
    int          timer;
    pending = 1'b0;
    addr    = '0;
    timer   = 0;
    forever begin
      @(negedge clk);
      imem_resp = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        check("req_hold_read", {31'b0, imem_read}, 32'd1);
        check("req_hold_addr", imem_address, addr);
        timer--;
        if (timer == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = ~addr;
          pending    = 1'b0;
        end
      end else if (imem_read) begin
        if (exp_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got 0x%08h, required no request", imem_address);
        end else begin
          check("req_addr", imem_address, exp_req.pop_front());
        end
        pending = 1'b1;
        addr    = imem_address;
        timer   = lat;
      end
    end
  end

  // Decode-side monitor: every accepted head is compared with the next expected PC
  initial begin : monitor
    logic [31:0] pc;
    forever begin
      @(negedge clk);
      if (rst_n && id_valid && id_ready) begin
        if (exp_pop.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc 0x%08h, required no pop", id_pc);
        end else begin
          pc = exp_pop.pop_front();
          check("pop_pc",      id_pc,      pc);
          check("pop_instr",   id_instr,   ~pc);
          check("pop_pc_next", id_pc_next, pc + 32'd4);
        end
      end
    end
  end

  initial begin : stimulus
    do_reset();

    // free flow, one-cycle cache, decode always ready
    lat = 1;
    id_ready = 1'b1;
    exp_req.push_back(32'h4000_0060);
    exp_req.push_back(32'h4000_0064);
    exp_req.push_back(32'h4000_0068);
    exp_req.push_back(32'h4000_006C);
    exp_pop.push_back(32'h4000_0060);
    exp_pop.push_back(32'h4000_0064);
    exp_pop.push_back(32'h4000_0068);
    repeat (7) @(posedge clk);
    #1;
    expect_drained("flow");
    do_reset();

    // backpressure until full, then a single-cycle pop
    lat = 1;
    exp_req.push_back(32'h4000_0060);
    exp_req.push_back(32'h4000_0064);
    exp_req.push_back(32'h4000_0068);
    exp_req.push_back(32'h4000_006C);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_no_req", {31'b0, imem_read}, 32'd0);
      check("full_valid",  {31'b0, id_valid},  32'd1);
    end
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    exp_pop.push_back(32'h4000_0060);
    exp_req.push_back(32'h4000_0070);
    @(posedge clk);
    #1;
    id_ready = 1'b0;
    @(negedge clk);
    check("refill_req", {31'b0, imem_read}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("refull_no_req", {31'b0, imem_read}, 32'd0);
    end
    @(posedge clk);
    #1;
    expect_drained("full");
    do_reset();

    // redirect while 0x40000068 is in flight; slow response must be dropped
    lat = 1;
    exp_req.push_back(32'h4000_0060);
    exp_req.push_back(32'h4000_0064);
    exp_req.push_back(32'h4000_0068);
    exp_req.push_back(32'h4000_0100);
    exp_req.push_back(32'h4000_0104);
    repeat (3) @(posedge clk);
    #1;
    lat = 4;
    repeat (2) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000_0100;
    redirect_jalr  = 1'b0;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    check("drop_flushed",   {31'b0, id_valid},  32'd0);
    check("drop_read_held", {31'b0, imem_read}, 32'd1);
    check("drop_addr_held", imem_address,       32'h4000_0068);
    @(negedge clk);
    check("drop_addr_held2", imem_address, 32'h4000_0068);
    @(negedge clk);
    check("drop_addr_held3", imem_address, 32'h4000_0068);
    @(negedge clk);
    check("drop_target_req", imem_address, 32'h4000_0100);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    exp_pop.push_back(32'h4000_0100);
    @(posedge clk);
    #1;
    expect_drained("drop");
    do_reset();

    // jalr masking, redirect while idle
    for (int j = 0; j < 2; j++) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h4000_0207;
      redirect_jalr  = (j == 0);
      exp_req.push_back((j == 0) ? 32'h4000_0206 : 32'h4000_0207);
      @(negedge clk);
      check("idle_redirect_no_req", {31'b0, imem_read}, 32'd0);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      redirect_jalr  = 1'b0;
      @(negedge clk);
      check("jalr_target", imem_address, (j == 0) ? 32'h4000_0206 : 32'h4000_0207);
      @(posedge clk);
      #1;
      expect_drained("jalr");
      do_reset();
    end

    // redirect, response and pop all in one cycle
    lat = 1;
    exp_req.push_back(32'h4000_0060);
    exp_req.push_back(32'h4000_0064);
    exp_req.push_back(32'h4000_0300);
    exp_pop.push_back(32'h4000_0060);
    repeat (3) @(posedge clk);
    #1;
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000_0300;
    @(negedge clk);
    check("simul_resp_seen", {31'b0, imem_resp}, 32'd1);
    @(posedge clk);
    #1;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("simul_empty",  {31'b0, id_valid},  32'd0);
    check("simul_req",    {31'b0, imem_read}, 32'd1);
    check("simul_target", imem_address,       32'h4000_0300);
    @(posedge clk);
    #1;
    expect_drained("simul");

    // reset while a request is outstanding, then restart from the reset PC
    do_reset();
    lat = 3;
    exp_req.push_back(32'h4000_0060);
    @(posedge clk);
    #1;
    expect_drained("midreq");
    do_reset();
    lat = 1;
    exp_req.push_back(32'h4000_0060);
    @(negedge clk);
    check("restart_addr", imem_address, 32'h4000_0060);
    @(posedge clk);
    #1;
    expect_drained("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
